// File: rtl/ca_row_writer.sv
// Elementary 1-D cellular automaton row producer: computes successive generations
// and streams each one, a byte per cycle, into a circular row buffer on RAM port A.
module ca_row_writer #(
  parameter int ADDR_BITS = 10,
  parameter int ROW_BYTES = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 step,
  input  logic [7:0]           rule,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          gen_count,
  output logic                 ram_we,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [7:0]           ram_data
);

  localparam int WIDTH  = 8 * ROW_BYTES;
  localparam int BYTE_W = $clog2(ROW_BYTES);
  localparam int PTR_W  = ADDR_BITS - BYTE_W;

  localparam logic [WIDTH-1:0]  SEED    = WIDTH'(1) << (WIDTH / 2);
  localparam logic [BYTE_W:0]   IDX_END = (BYTE_W + 1)'(ROW_BYTES);
  localparam logic [BYTE_W:0]   IDX_ONE = (BYTE_W + 1)'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_CALC, S_WRITE} state_t;

  state_t               state, state_n;
  logic [WIDTH-1:0]     cur, cur_n;
  logic [PTR_W-1:0]     ptr, ptr_n;
  logic [BYTE_W:0]      idx, idx_n;
  logic [7:0]           rule_q, rule_n;
  logic                 busy_n, done_n, we_n;
  logic [15:0]          gen_n;
  logic [ADDR_BITS-1:0] addr_n;
  logic [7:0]           data_n;
  logic [WIDTH-1:0]     next_row;

  // cur[c] holds cell c; cell c maps to byte c/8, bit 7-(c%8), so the
  // leftmost cell of each byte lands in its MSB.
  function automatic logic [7:0] row_byte(input logic [WIDTH-1:0] row,
                                          input logic [BYTE_W-1:0] k);
    logic [7:0] b;
    b = '0;
    for (int j = 0; j < 8; j++) begin
      b[7-j] = row[{k, 3'(j)}];
    end
    return b;
  endfunction

  // Toroidal neighbourhood: cell 0's left neighbour is cell WIDTH-1.
  always_comb begin
    next_row = '0;
    for (int c = 0; c < WIDTH; c++) begin
      next_row[c] = rule_q[{cur[(c + WIDTH - 1) % WIDTH], cur[c], cur[(c + 1) % WIDTH]}];
    end
  end

  always_comb begin
    state_n = state;
    cur_n   = cur;
    ptr_n   = ptr;
    idx_n   = idx;
    rule_n  = rule_q;
    busy_n  = busy;
    done_n  = 1'b0;
    gen_n   = gen_count;
    we_n    = 1'b0;
    addr_n  = ram_addr;
    data_n  = ram_data;
    case (state)
      // INIT and WRITE share the byte streamer; only WRITE reports a generation.
      S_INIT, S_WRITE: begin
        busy_n = 1'b1;
        if (idx == IDX_END) begin
          state_n = S_IDLE;
          busy_n  = 1'b0;
          idx_n   = '0;
          if (state == S_WRITE) begin
            done_n = 1'b1;
            gen_n  = gen_count + 16'd1;
          end
        end else begin
          we_n   = 1'b1;
          addr_n = {ptr, idx[BYTE_W-1:0]};
          data_n = row_byte(cur, idx[BYTE_W-1:0]);
          idx_n  = idx + IDX_ONE;
        end
      end
      S_IDLE: begin
        if (step) begin
          rule_n  = rule;
          state_n = S_CALC;
          busy_n  = 1'b1;
        end
      end
      S_CALC: begin
        // Byte 0 of the new row goes out on the same edge that commits it.
        cur_n   = next_row;
        ptr_n   = ptr + PTR_ONE;
        we_n    = 1'b1;
        addr_n  = {ptr + PTR_ONE, {BYTE_W{1'b0}}};
        data_n  = row_byte(next_row, '0);
        idx_n   = IDX_ONE;
        state_n = S_WRITE;
      end
      default: state_n = S_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_INIT;
      cur       <= SEED;
      ptr       <= '0;
      idx       <= '0;
      rule_q    <= '0;
      busy      <= 1'b1;
      done      <= 1'b0;
      gen_count <= '0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_data  <= '0;
    end else begin
      state     <= state_n;
      cur       <= cur_n;
      ptr       <= ptr_n;
      idx       <= idx_n;
      rule_q    <= rule_n;
      busy      <= busy_n;
      done      <= done_n;
      gen_count <= gen_n;
      ram_we    <= we_n;
      ram_addr  <= addr_n;
      ram_data  <= data_n;
    end
  end

endmodule
